// File: rtl/block_accumulator_if.sv
// Memory/control bundle for block_accumulator: start/status handshake plus a
// synchronous-RAM port (read data arrives the cycle after the read strobe).
interface block_accumulator_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] acc_data_out;
  logic              busy;
  logic              ready;
  logic              overflow;

  // The accumulator masters the memory bus.
  modport master (
    input  start,
    input  mem_data_in,
    output mem_read_enable,
    output mem_write_enable,
    output mem_address,
    output acc_data_out,
    output busy,
    output ready,
    output overflow
  );

  modport slave (
    output start,
    output mem_data_in,
    input  mem_read_enable,
    input  mem_write_enable,
    input  mem_address,
    input  acc_data_out,
    input  busy,
    input  ready,
    input  overflow
  );
endinterface

// File: rtl/block_accumulator.sv
// Sums BLOCK_LEN-1 operand words per block and writes the sum into the block's last word.
// Define BLOCK_ACC_SATURATE_EN to clamp block sums at 2**DATA_W-1 instead of wrapping.
module block_accumulator #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned BLOCK_LEN  = 8,
  parameter int unsigned NUM_BLOCKS = 4
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  block_accumulator_if.master bus_io
);

  localparam int unsigned WORD_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN - 1) : 1;
  localparam int unsigned BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_LEN - 2);
  localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [ADDR_W-1:0] BLK_SIZE  = ADDR_W'(BLOCK_LEN);
  localparam logic [ADDR_W-1:0] DST_OFS   = ADDR_W'(BLOCK_LEN - 1);

  if (BLOCK_LEN < 2) begin : g_bad_len
    $error("block_accumulator: BLOCK_LEN must be at least 2");
  end
  if (NUM_BLOCKS < 1) begin : g_bad_blocks
    $error("block_accumulator: NUM_BLOCKS must be at least 1");
  end
  if (longint'(BLOCK_LEN) * longint'(NUM_BLOCKS) > (longint'(1) << ADDR_W)) begin : g_bad_span
    $error("block_accumulator: BLOCK_LEN*NUM_BLOCKS exceeds the address space");
  end

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StAcc,
    StWr,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] sum_nxt;
  logic [ADDR_W-1:0] base_addr;

  assign sum_ext   = {1'b0, sum_q} + {1'b0, bus_io.mem_data_in};
  assign base_addr = ADDR_W'(blk_q) * BLK_SIZE;

`ifdef BLOCK_ACC_SATURATE_EN
  // Once clamped, further adds of non-negative words keep the sum at the ceiling.
  assign sum_nxt = sum_ext[DATA_W] ? {DATA_W{1'b1}} : sum_ext[DATA_W-1:0];
`else
  assign sum_nxt = sum_ext[DATA_W-1:0];
`endif

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      blk_q   <= '0;
      word_q  <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are decoded from state so reset forces them low without a clock edge.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    word_d  = word_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    bus_io.mem_read_enable  = 1'b0;
    bus_io.mem_write_enable = 1'b0;
    bus_io.mem_address      = '0;
    bus_io.acc_data_out     = '0;
    bus_io.busy             = 1'b0;
    bus_io.ready            = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StRd;
          blk_d   = '0;
          word_d  = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StRd: begin
        bus_io.busy            = 1'b1;
        bus_io.mem_read_enable = 1'b1;
        bus_io.mem_address     = base_addr + ADDR_W'(word_q);
        state_d                = StAcc;
      end
      StAcc: begin
        bus_io.busy = 1'b1;
        sum_d       = sum_nxt;
        if (sum_ext[DATA_W]) begin
          ovf_d = 1'b1;
        end
        if (word_q != LAST_WORD) begin
          word_d  = word_q + WORD_W'(1);
          state_d = StRd;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        bus_io.busy             = 1'b1;
        bus_io.mem_write_enable = 1'b1;
        bus_io.mem_address      = base_addr + DST_OFS;
        bus_io.acc_data_out     = sum_q;
        sum_d                   = '0;
        word_d                  = '0;
        if (blk_q != LAST_BLK) begin
          blk_d   = blk_q + BLK_W'(1);
          state_d = StRd;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        bus_io.ready = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.overflow = ovf_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Scoreboard bench for block_accumulator: default instance plus a BLOCK_LEN=4, NUM_BLOCKS=8 one.
module tb_block_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_accumulator_if #(.DATA_W(16), .ADDR_W(5)) bus ();
  block_accumulator_if #(.DATA_W(16), .ADDR_W(5)) bus2 ();

  block_accumulator #(.DATA_W(16), .ADDR_W(5), .BLOCK_LEN(8), .NUM_BLOCKS(4)) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus_io  (bus)
  );

  block_accumulator #(.DATA_W(16), .ADDR_W(5), .BLOCK_LEN(4), .NUM_BLOCKS(8)) dut2 (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus_io  (bus2)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  localparam logic [15:0] RAMP_SUM [4] = '{16'd21, 16'd77, 16'd133, 16'd189};
`ifdef BLOCK_ACC_SATURATE_EN
  localparam logic [15:0] ONES_SUM = 16'hFFFF;
`else
  localparam logic [15:0] ONES_SUM = 16'hFFF9;
`endif

  logic [15:0] ram  [32];
  logic [15:0] ram2 [32];
  wr_t exp_q[$];
  wr_t exp2_q[$];
  int total = 0;
  int bad = 0;
  int rd_cnt, wr_cnt, rdy_cnt, rd2_cnt, wr2_cnt, rdy2_cnt;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Synchronous RAM models: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_read_enable)  bus.mem_data_in  <= ram[bus.mem_address];
    if (bus2.mem_read_enable) bus2.mem_data_in <= ram2[bus2.mem_address];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_read_enable) rd_cnt++;
    if (bus.ready) rdy_cnt++;
    check("rd_wr_exclusive", 32'(bus.mem_read_enable & bus.mem_write_enable), 32'd0);
    if (!bus.mem_read_enable && !bus.mem_write_enable)
      check("addr_idle_zero", 32'(bus.mem_address), 32'd0);
    if (bus.mem_write_enable) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h required none",
                 bus.mem_address, bus.acc_data_out);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_address), 32'(e.addr));
        check("wr_data", 32'(bus.acc_data_out), 32'(e.data));
      end
    end else begin
      check("acc_idle_zero", 32'(bus.acc_data_out), 32'd0);
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (bus2.mem_read_enable) rd2_cnt++;
    if (bus2.ready) rdy2_cnt++;
    if (bus2.mem_write_enable) begin
      wr2_cnt++;
      if (exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write2: got addr %0d data %0h required none",
                 bus2.mem_address, bus2.acc_data_out);
      end else begin
        e = exp2_q.pop_front();
        check("wr2_addr", 32'(bus2.mem_address), 32'(e.addr));
        check("wr2_data", 32'(bus2.acc_data_out), 32'(e.data));
      end
    end
  end

  task automatic clr_counts();
    rd_cnt = 0; wr_cnt = 0; rdy_cnt = 0;
    rd2_cnt = 0; wr2_cnt = 0; rdy2_cnt = 0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 32; i++) begin
      ram[i]  = 16'(i);
      ram2[i] = 16'(i);
    end
  endtask

  task automatic push_ramp();
    for (int b = 0; b < 4; b++) exp_q.push_back('{addr: 5'(8 * b + 7), data: RAMP_SUM[b]});
  endtask

  task automatic start_pulse(output int st);
    @(negedge clk);
    bus.start = 1'b1;
    st = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input int max_cyc, output int seen);
    seen = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready required ready within %0d cycles", max_cyc);
    end
  endtask

  task automatic outputs_zero(input string name);
    check(name, 32'({bus.mem_read_enable, bus.mem_write_enable, bus.mem_address,
                     bus.acc_data_out, bus.busy, bus.ready, bus.overflow}), 32'd0);
  endtask

  task automatic run_ramp(input string tag);
    int st, rc;
    clr_counts();
    push_ramp();
    start_pulse(st);
    wait_ready(200, rc);
    check({tag, "_latency"}, 32'(rc - st), 32'd61);
    check({tag, "_busy_at_ready"}, 32'(bus.busy), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_reads"}, 32'(rd_cnt), 32'd28);
    check({tag, "_writes"}, 32'(wr_cnt), 32'd4);
    check({tag, "_readies"}, 32'(rdy_cnt), 32'd1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int st, rc, n;
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    fill_ramp();
    clr_counts();
    #12;
    outputs_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_ramp("ramp");

    // Starts during a run must not queue a second run.
    clr_counts();
    push_ramp();
    start_pulse(st);
    while (cyc < st + 5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < st + 30) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready(200, rc);
    repeat (80) @(negedge clk);
    check("ignore_reads", 32'(rd_cnt), 32'd28);
    check("ignore_writes", 32'(wr_cnt), 32'd4);
    check("ignore_readies", 32'(rdy_cnt), 32'd1);

    // Start held high: two back-to-back runs.
    clr_counts();
    push_ramp();
    push_ramp();
    @(negedge clk);
    bus.start = 1'b1;
    n = 0;
    for (int i = 0; i < 300 && n < 2; i++) begin
      @(negedge clk);
      if (bus.ready) n++;
    end
    bus.start = 1'b0;
    check("held_ready_pulses", 32'(n), 32'd2);
    repeat (80) @(negedge clk);
    check("held_reads", 32'(rd_cnt), 32'd56);
    check("held_writes", 32'(wr_cnt), 32'd8);
    check("held_readies", 32'(rdy_cnt), 32'd2);
    check("held_queue_empty", 32'(exp_q.size()), 32'd0);

    // All-ones operands overflow every block.
    for (int i = 0; i < 32; i++) ram[i] = 16'hFFFF;
    clr_counts();
    for (int b = 0; b < 4; b++) exp_q.push_back('{addr: 5'(8 * b + 7), data: ONES_SUM});
    start_pulse(st);
    wait_ready(200, rc);
    check("ones_overflow", 32'(bus.overflow), 32'd1);
    repeat (3) @(negedge clk);
    check("ones_overflow_sticky", 32'(bus.overflow), 32'd1);
    check("ones_writes", 32'(wr_cnt), 32'd4);
    check("ones_queue_empty", 32'(exp_q.size()), 32'd0);

    // A new start clears the sticky overflow.
    fill_ramp();
    run_ramp("after_ovf");

    // Reset mid-run aborts; only block 0 gets written.
    clr_counts();
    exp_q.push_back('{addr: 5'd7, data: 16'd21});
    start_pulse(st);
    while (cyc < st + 20) @(negedge clk);
    check("busy_midrun", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 outputs_zero("async_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (90) @(negedge clk);
    check("abort_writes", 32'(wr_cnt), 32'd1);
    check("abort_readies", 32'(rdy_cnt), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    run_ramp("post_reset");

    // Short-block instance.
    clr_counts();
    for (int b = 0; b < 8; b++) exp2_q.push_back('{addr: 5'(4 * b + 3), data: 16'(12 * b + 3)});
    @(negedge clk);
    bus2.start = 1'b1;
    st = cyc;
    @(negedge clk);
    bus2.start = 1'b0;
    rc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus2.ready) begin
        rc = cyc;
        break;
      end
    end
    check("short_latency", 32'(rc - st), 32'd57);
    repeat (3) @(negedge clk);
    check("short_reads", 32'(rd2_cnt), 32'd24);
    check("short_writes", 32'(wr2_cnt), 32'd8);
    check("short_readies", 32'(rdy2_cnt), 32'd1);
    check("short_overflow", 32'(bus2.overflow), 32'd0);
    check("short_queue_empty", 32'(exp2_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/block_accumulator.md
BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

Interface
REQ-001 Parameter DATA_W, default 16: width of memory words and block sums.
REQ-002 Parameter ADDR_W, default 5: memory address width.
REQ-003 Parameter BLOCK_LEN, default 8, minimum 2: words per block.
- The first BLOCK_LEN-1 words of a block are operands.
- The last word of a block is the sum destination.
REQ-004 Parameter NUM_BLOCKS, default 4: blocks per run; BLOCK_LEN*NUM_BLOCKS SHALL NOT exceed 2**ADDR_W (elaboration-time error otherwise).
REQ-005 clock  input  1  single clock; all state changes on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  run request; sampled only in IDLE.
REQ-008 mem_data_in  input  DATA_W  read data from synchronous RAM, valid the cycle after mem_read_enable.
REQ-009 mem_read_enable  output  1  one-cycle read strobe.
REQ-010 mem_write_enable  output  1  one-cycle write strobe.
REQ-011 mem_address  output  ADDR_W  address for the current read or write.
REQ-012 acc_data_out  output  DATA_W  write data, equal to the running sum.
REQ-013 busy  output  1  high from run acceptance until the DONE state.
REQ-014 ready  output  1  one-cycle pulse on run completion.
REQ-015 overflow  output  1  sticky; set if any block sum exceeded 2**DATA_W-1 during the current run.

Function
REQ-016 FSM states: IDLE, RD, ACC, WR, DONE.
- IDLE->RD when start=1: clears the block index, word index, sum and overflow; sets busy.
REQ-017 RD, one cycle:
- mem_read_enable=1.
- mem_address = block*BLOCK_LEN + word.
- Next state ACC.
REQ-018 ACC, one cycle:
- mem_read_enable=0.
- sum <= sum + mem_data_in, computed at DATA_W+1 bits.
- If word < BLOCK_LEN-2: word increments, next state RD; otherwise next state WR.
- Strobes SHALL therefore deassert between consecutive reads (one rising edge per read).
REQ-019 WR, one cycle:
- mem_write_enable=1.
- mem_address = block*BLOCK_LEN + BLOCK_LEN-1.
- acc_data_out = sum.
- Then sum and word clear.
- If block < NUM_BLOCKS-1: block increments, next state RD; otherwise next state DONE.
REQ-020 DONE, one cycle: ready=1, busy=0; next state IDLE.
REQ-021 Latency:
- 2*(BLOCK_LEN-1)+1 cycles per block.
- start-to-ready = NUM_BLOCKS*(2*BLOCK_LEN-1)+1 cycles (61 at defaults).
REQ-022 Strobe counts per run: exactly NUM_BLOCKS*(BLOCK_LEN-1) read strobes, NUM_BLOCKS write strobes and one ready pulse.
REQ-023 start while busy, or in the DONE cycle, SHALL be ignored; a start held high re-launches a run from the IDLE cycle following DONE.
REQ-024 mem_read_enable and mem_write_enable SHALL never be high in the same cycle.
REQ-025 Outside RD and WR, mem_address SHALL be 0.
REQ-026 acc_data_out SHALL be 0 except in WR.
REQ-027 Address arithmetic SHALL NOT wrap within a run (guaranteed by REQ-004).

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for a clock edge:
- force the FSM to IDLE;
- clear the indices and sum;
- drive all outputs to 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no further strobes and no ready pulse.
REQ-030 After reset_n deasserts, the block SHALL wait for a new start.

Configuration
REQ-031 Macro BLOCK_ACC_SATURATE_EN defined:
- On carry-out, the sum clamps to 2**DATA_W-1 and stays clamped for the remainder of the block.
- overflow sets.
REQ-032 Macro BLOCK_ACC_SATURATE_EN undefined:
- The sum wraps modulo 2**DATA_W.
- overflow still sets on carry-out.

Verification
REQ-033 Defaults, RAM[i]=i, one start ->
- writes at addresses 7/15/23/31 of 21/77/133/189;
- 28 read strobes, 4 write strobes, 1 ready pulse 61 cycles after start;
- overflow=0.
REQ-034 Two runs back-to-back (start held high) -> 56 read strobes, 8 write strobes, 2 ready pulses.
REQ-035 Defaults, RAM all 0xFFFF ->
- with BLOCK_ACC_SATURATE_EN: each write 0xFFFF, overflow=1;
- without: each write 0xFFF9, overflow=1.
REQ-036 reset_n pulsed low at cycle 20 of a run -> outputs 0 within the same cycle; no write to 15/23/31; no ready; a later start gives REQ-033 results.
REQ-037 start pulsed at cycles 5 and 30 of a run -> ignored: exactly 4 writes and 1 ready.
REQ-038 BLOCK_LEN=4, NUM_BLOCKS=8, RAM[i]=i -> writes at 3,7,...,31 of 3,15,27,...,87; 24 read strobes.
